// File: rtl/sram_master.sv
// rtl/sram_master.sv - single-word request/response initiator for the sram chip-select port
// Strobes are held for WAIT_CYCLES+1 cycles; misaligned requests answer with resp_err and no access.
module sram_master #(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              cs,
   output logic              oe,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] din,
   input  logic [DATA_W-1:0] dout,
   output logic [15:0]       txn_count
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t              r_state,      w_state_nx;
   logic                r_req_ready,  w_req_ready_nx;
   logic                r_is_wr,      w_is_wr_nx;
   logic [3:0]          r_wait,       w_wait_nx;
   logic                r_cs,         w_cs_nx;
   logic                r_oe,         w_oe_nx;
   logic                r_we,         w_we_nx;
   logic [ADDR_W-1:0]   r_addr,       w_addr_nx;
   logic [DATA_W-1:0]   r_din,        w_din_nx;
   logic                r_resp_valid, w_resp_valid_nx;
   logic [DATA_W-1:0]   r_resp_rdata, w_resp_rdata_nx;
   logic                r_resp_err,   w_resp_err_nx;
   logic [15:0]         r_txn_count,  w_txn_count_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b0;
         r_is_wr      <= 1'b0;
         r_wait       <= '0;
         r_cs         <= 1'b0;
         r_oe         <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_din        <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         r_txn_count  <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_req_ready  <= w_req_ready_nx;
         r_is_wr      <= w_is_wr_nx;
         r_wait       <= w_wait_nx;
         r_cs         <= w_cs_nx;
         r_oe         <= w_oe_nx;
         r_we         <= w_we_nx;
         r_addr       <= w_addr_nx;
         r_din        <= w_din_nx;
         r_resp_valid <= w_resp_valid_nx;
         r_resp_rdata <= w_resp_rdata_nx;
         r_resp_err   <= w_resp_err_nx;
         r_txn_count  <= w_txn_count_nx;
      end
   end

   always_comb begin
      w_state_nx      = r_state;
      w_req_ready_nx  = r_req_ready;
      w_is_wr_nx      = r_is_wr;
      w_wait_nx       = r_wait;
      w_cs_nx         = r_cs;
      w_oe_nx         = r_oe;
      w_we_nx         = r_we;
      w_addr_nx       = r_addr;
      w_din_nx        = r_din;
      w_resp_valid_nx = r_resp_valid;
      w_resp_rdata_nx = r_resp_rdata;
      w_resp_err_nx   = r_resp_err;
      w_txn_count_nx  = r_txn_count;
      case (r_state)
         S_IDLE: begin
            // req_ready comes up one edge after reset release, so that edge never accepts
            w_req_ready_nx = 1'b1;
            if (req_valid && r_req_ready) begin
               w_req_ready_nx = 1'b0;
               w_is_wr_nx     = req_we;
               if (req_addr[1:0] != 2'b00) begin
                  w_state_nx      = S_RESP;
                  w_resp_valid_nx = 1'b1;
                  w_resp_err_nx   = 1'b1;
                  w_resp_rdata_nx = '0;
               end else begin
                  w_state_nx = S_ACCESS;
                  w_wait_nx  = 4'(WAIT_CYCLES);
                  w_cs_nx    = 1'b1;
                  w_we_nx    = req_we;
                  w_oe_nx    = !req_we;
                  w_addr_nx  = req_addr;
                  w_din_nx   = req_we ? req_wdata : '0;
               end
            end
         end
         S_ACCESS: begin
            if (r_wait == 4'd0) begin
               w_resp_rdata_nx = r_is_wr ? '0 : dout;
               w_cs_nx         = 1'b0;
               w_oe_nx         = 1'b0;
               w_we_nx         = 1'b0;
               w_din_nx        = '0;
               w_resp_valid_nx = 1'b1;
               w_resp_err_nx   = 1'b0;
               w_state_nx      = S_RESP;
            end else begin
               w_wait_nx = r_wait - 4'd1;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               w_resp_valid_nx = 1'b0;
               w_resp_err_nx   = 1'b0;
               w_txn_count_nx  = r_txn_count + 16'd1;
               w_req_ready_nx  = 1'b1;
               w_state_nx      = S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign cs         = r_cs;
   assign oe         = r_oe;
   assign we         = r_we;
   assign addr       = r_addr;
   assign din        = r_din;
   assign txn_count  = r_txn_count;

endmodule

// File: tb/tb_sram_master.sv
// tb/tb_sram_master.sv - table-driven and randomized checks of sram_master against a memory/count model
module tb_sram_master;
   localparam int W = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        cs, oe, we;
   logic [31:0] addr, din, dout;
   logic [15:0] txn_count;

   sram_master #(.WAIT_CYCLES(W), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .cs(cs), .oe(oe), .we(we), .addr(addr), .din(din), .dout(dout),
      .txn_count(txn_count)
   );

   always #5 clk = ~clk;

   // Simple SRAM: combinational read while cs&oe, write on the edge while cs&we.
   logic [31:0] sram_mem [0:255];
   always @(posedge clk) begin
      if (rst) sram_mem[20] <= 32'h3C011001;
      else if (cs && we) sram_mem[addr[9:2]] <= din;
   end
   always_comb begin
      dout = 32'h0;
      if (cs && oe) dout = sram_mem[addr[9:2]];
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          hold;
      logic        imm;
   } vec_t;

   int          n_vec = 0;
   int          n_err = 0;
   int          m_txn = 0;
   logic [31:0] ref_mem [logic [31:0]];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input vec_t v);
      int waited = 0;
      int lat    = 1;
      int cs_cyc = 0;
      while (!req_ready && waited < 20) begin
         tick();
         waited++;
      end
      chk("req_ready_seen", 64'(req_ready), 64'd1);
      if (v.imm) chk("accept_immediately", 64'(waited), 64'd0);
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
      tick();
      req_valid = 1'b0;
      chk("ready_low_after_accept", 64'(req_ready), 64'd0);
      while (!resp_valid && lat < 40) begin
         if (cs) begin
            cs_cyc++;
            chk("strobe_oe", 64'(oe), 64'(!v.we));
            chk("strobe_we", 64'(we), 64'(v.we));
            chk("strobe_addr", 64'(addr), 64'(v.addr));
            chk("strobe_din", 64'(din), v.we ? 64'(v.wdata) : 64'd0);
         end
         tick();
         lat++;
      end
      chk("resp_valid_seen", 64'(resp_valid), 64'd1);
      chk("resp_latency", 64'(lat), v.exp_err ? 64'd1 : 64'(W + 2));
      chk("cs_cycles", 64'(cs_cyc), v.exp_err ? 64'd0 : 64'(W + 1));
      chk("strobes_idle", 64'({cs, oe, we}), 64'd0);
      chk("resp_err", 64'(resp_err), 64'(v.exp_err));
      chk("resp_rdata", 64'(resp_rdata), 64'(v.exp_rdata));
      for (int h = 0; h < v.hold; h++) begin
         resp_ready = 1'b0;
         if (h == 0) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h00400050; req_wdata = 32'h0;
         end
         tick();
         chk("hold_valid", 64'(resp_valid), 64'd1);
         chk("hold_rdata", 64'(resp_rdata), 64'(v.exp_rdata));
         chk("hold_err", 64'(resp_err), 64'(v.exp_err));
         chk("hold_req_ready", 64'(req_ready), 64'd0);
         chk("hold_cs", 64'(cs), 64'd0);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      m_txn = (m_txn + 1) % 65536;
      chk("resp_dropped", 64'(resp_valid), 64'd0);
      chk("txn_count", 64'(txn_count), 64'(m_txn));
      chk("ready_after_resp", 64'(req_ready), 64'd1);
      if (!v.exp_err && v.we) ref_mem[v.addr] = v.wdata;
   endtask

   vec_t vecs [7];

   initial begin
      vec_t v;
      vecs[0] = '{1'b1, 32'h10000024, 32'h0000000E, 1'b0, 32'h0,        0, 1'b0};
      vecs[1] = '{1'b0, 32'h10000024, 32'h0,        1'b0, 32'h0000000E, 0, 1'b0};
      vecs[2] = '{1'b0, 32'h00400050, 32'h0,        1'b0, 32'h3C011001, 0, 1'b0};
      vecs[3] = '{1'b0, 32'h00400052, 32'h0,        1'b1, 32'h0,        0, 1'b0};
      vecs[4] = '{1'b1, 32'h10000101, 32'hDEADBEEF, 1'b1, 32'h0,        0, 1'b0};
      vecs[5] = '{1'b0, 32'h10000024, 32'h0,        1'b0, 32'h0000000E, 3, 1'b0};
      vecs[6] = '{1'b0, 32'h00400050, 32'h0,        1'b0, 32'h3C011001, 0, 1'b1};
      ref_mem[32'h00400050] = 32'h3C011001;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_outputs", 64'({cs, oe, we, resp_valid, resp_err, req_ready}), 64'd0);
         chk("rst_regs", {addr, txn_count, 16'(din)}, 64'd0);
      end
      rst = 1'b0;
      #1;
      chk("ready_before_edge", 64'(req_ready), 64'd0);
      tick();
      chk("ready_after_release", 64'(req_ready), 64'd1);
      chk("idle_outputs", 64'({cs, oe, we, resp_valid}), 64'd0);
      chk("idle_txn", 64'(txn_count), 64'd0);

      for (int i = 0; i < 7; i++) run_txn(vecs[i]);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         a = 32'h10000000 + (32'($urandom_range(64, 255)) << 2);
         v.hold = $urandom_range(0, 2);
         v.imm = 1'b0;
         v.wdata = $urandom;
         v.we = 1'($urandom_range(0, 1));
         v.exp_err = ($urandom_range(0, 5) == 0);
         if (v.exp_err) a = a | 32'($urandom_range(1, 3));
         else if (!v.we && !ref_mem.exists(a)) v.we = 1'b1;
         v.addr = a;
         v.exp_rdata = (v.we || v.exp_err) ? 32'h0 : ref_mem[a];
         run_txn(v);
      end

      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10000200; req_wdata = 32'h12345678;
      tick();
      req_valid = 1'b0;
      chk("midrst_cs_up", 64'({cs, we}), 64'd3);
      #1 rst = 1'b1;
      #1;
      chk("midrst_strobes", 64'({cs, oe, we}), 64'd0);
      chk("midrst_resp", 64'(resp_valid), 64'd0);
      chk("midrst_txn", 64'(txn_count), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      m_txn = 0;
      tick();
      chk("midrst_ready", 64'(req_ready), 64'd1);
      chk("midrst_no_resp", 64'(resp_valid), 64'd0);
      run_txn(vecs[1]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sram_master.md
Name: sram_master

Overview:
Initiator for the unified `sram` model's chip-select interface (cs/oe/we/addr/din/dout). It accepts single-word read/write requests from the CPU datapath over a valid/ready handshake and sequences the SRAM strobes with a programmable number of wait cycles. It returns read data or write completion over a second valid/ready handshake. It sits between the pipeline's memory stage and the `sram` instance and replaces ad-hoc bench-style strobe driving.

Parameters:
WAIT_CYCLES, 1, extra cycles cs is held beyond the first access cycle (legal 0..15)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  master can accept a request
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  byte address, must be word aligned
req_wdata  input  DATA_W  write data
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  DATA_W  read data (0 for writes and errors)
resp_err  output  1  misaligned request, no SRAM access performed
cs  output  1  SRAM chip select
oe  output  1  SRAM output enable
we  output  1  SRAM write enable
addr  output  ADDR_W  SRAM address
din  output  DATA_W  SRAM write data
dout  input  DATA_W  SRAM read data
txn_count  output  16  completed responses, wraps 0xFFFF->0x0000

Behaviour:
- All outputs are registered.
- Reset (async, immediate):
  - state=IDLE.
  - req_ready=0 while rst is high; req_ready=1 on the first clk edge after release.
  - cs, oe, we, resp_valid and resp_err are 0.
  - addr, din, resp_rdata and txn_count are 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid&&req_ready at an edge) latches req_we, req_addr and req_wdata, and sets req_ready=0.
  - If req_addr[1:0]!=0: go to RESP with resp_err=1, resp_rdata=0; cs stays 0.
  - Otherwise: go to ACCESS and load wait counter=WAIT_CYCLES.
- ACCESS:
  - cs=1, addr=latched address.
  - Write: we=1, oe=0, din=wdata.
  - Read: oe=1, we=0, din=0.
  - oe and we are never both 1; when cs=0, both oe and we are 0.
  - addr and din are stable for the whole ACCESS period.
  - Lasts exactly WAIT_CYCLES+1 cycles; the counter decrements each edge.
  - On the edge where the counter is 0:
    - Capture dout into resp_rdata for reads; resp_rdata=0 for writes.
    - Drop cs, oe and we to 0; drive din=0.
    - Set resp_valid=1, resp_err=0, and go to RESP.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_valid&&resp_ready at an edge.
  - On that edge: resp_valid=0, txn_count+=1 (error responses also count), state=IDLE, req_ready=1.
- Latency: request accepted at edge N -> cs high during cycles N+1..N+1+WAIT_CYCLES -> resp_valid high after edge N+1+WAIT_CYCLES. Best-case throughput is one transaction per WAIT_CYCLES+3 cycles.
- Requests presented while req_ready=0 are ignored; no queueing.
- resp_ready asserted while resp_valid=0 has no effect.
- txn_count: 16-bit unsigned, modulo 2^16.
- Reset mid-ACCESS or mid-RESP:
  - Strobes drop asynchronously.
  - The pending response is discarded; txn_count is cleared.
  - A partially strobed write has undefined effect on SRAM contents.

Test Plan:
1. Reset, then idle: rst=1 for 2 cycles with req_valid=0, then release -> cs/oe/we/resp_valid=0, txn_count=0 throughout; req_ready=1 one edge after release.
2. Write, WAIT_CYCLES=1: req_we=1, addr=0x10000024, wdata=0x0000000E -> cs=1, we=1, oe=0, addr=0x10000024, din=0x0E for exactly 2 cycles; resp_valid=1, resp_rdata=0, resp_err=0; txn_count=1 after resp_ready.
3. Read-back: read of 0x10000024 -> oe=1, we=0 for 2 cycles; resp_rdata=0x0000000E. Read of 0x00400050 with bills_branch.dat preloaded -> resp_rdata equals that file's word at 0x00400050.
4. Misaligned: read of 0x00400052 -> cs never asserts; resp_valid one edge after acceptance with resp_err=1, resp_rdata=0; txn_count increments.
5. Backpressure: resp_ready=0 for 3 cycles after a read response while a new req_valid is held -> resp_valid and resp_rdata stable, req_ready=0, second request not accepted. Raise resp_ready -> second request accepted the edge after return to IDLE.
6. Reset mid-ACCESS: assert rst in the first ACCESS cycle of a write -> cs/we drop without waiting for clk, no resp_valid, txn_count=0. A post-reset transaction completes normally.
